// File: rtl/lock_sequencer.sv
// lock_sequencer: two-button digital combination lock.
//
// An attempt is CODE_LEN presses, each either digit 0 (Button_0) or digit 1
// (Button_1). A matching attempt opens the lock for UNLOCK_CYCLES clocks.
// MAX_FAIL consecutive bad attempts lock the pad out for LOCKOUT_CYCLES
// clocks. A partial attempt with no press for TIMEOUT_CYCLES clocks is
// discarded. The code can be reprogrammed from IDLE via code_wr/code_in.
//
// Ports
//   clk        system clock, rising-edge active
//   rst        asynchronous active-low reset
//   Button_0   digit-0 press
//   Button_1   digit-1 press
//   code_wr    one-cycle strobe, loads code_in (honoured in IDLE only)
//   code_in    new code, bit k is digit k
//   unlock     high while the lock is open
//   lockout    high while the pad is locked out
//   fail_cnt   consecutive failed attempts
//   entry_cnt  digits captured in the current attempt
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for the first digit; code_wr accepted here
// ENTRY   | collecting digits, idle-gap timer running
// CHECK   | one cycle: judge the attempt, update fail_cnt
// OPEN    | one settle cycle, then unlock high for UNLOCK_CYCLES
// LOCKOUT | lockout high for LOCKOUT_CYCLES, presses ignored
module lock_sequencer #(
  parameter int                  CODE_LEN       = 5,
  parameter logic [CODE_LEN-1:0] DEFAULT_CODE   = 5'b01011,
  parameter int                  MAX_FAIL       = 3,
  parameter int                  UNLOCK_CYCLES  = 16,
  parameter int                  LOCKOUT_CYCLES = 64,
  parameter int                  TIMEOUT_CYCLES = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                Button_0,
  input  logic                Button_1,
  input  logic                code_wr,
  input  logic [CODE_LEN-1:0] code_in,
  output logic                unlock,
  output logic                lockout,
  output logic [1:0]          fail_cnt,
  output logic [2:0]          entry_cnt
);

  localparam int T_MAX_A = (UNLOCK_CYCLES > LOCKOUT_CYCLES) ? UNLOCK_CYCLES : LOCKOUT_CYCLES;
  localparam int T_MAX   = (T_MAX_A > TIMEOUT_CYCLES) ? T_MAX_A : TIMEOUT_CYCLES;
  localparam int TW      = $clog2(T_MAX + 1);

  // OPEN spends its first cycle with unlock still low, so its timer is
  // loaded with the full count; the other timers terminate one cycle earlier.
  localparam logic [TW-1:0] UNLOCK_LOAD  = TW'(UNLOCK_CYCLES);
  localparam logic [TW-1:0] LOCKOUT_LOAD = TW'(LOCKOUT_CYCLES - 1);
  localparam logic [TW-1:0] TIMEOUT_LOAD = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [2:0]    LAST_IDX     = 3'(CODE_LEN - 1);
  localparam logic [1:0]    FAIL_LIMIT   = 2'(MAX_FAIL);

  typedef enum logic [2:0] {
    IDLE,
    ENTRY,
    CHECK,
    OPEN,
    LOCKOUT
  } state_t;

  state_t              state;
  logic [CODE_LEN-1:0] code_q;
  logic [CODE_LEN-1:0] att_code;
  logic [TW-1:0]       timer;
  logic                err;

  logic press_valid;
  logic press_bad;
  logic digit;

  always_comb begin
    press_valid = Button_0 ^ Button_1;
    press_bad   = Button_0 & Button_1;
    digit       = Button_1;
  end

  // att_code snapshots the code at the start of an attempt so that a code
  // written in the same cycle as the first press only affects later attempts.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      unlock    <= 1'b0;
      lockout   <= 1'b0;
      fail_cnt  <= 2'd0;
      entry_cnt <= 3'd0;
      code_q    <= DEFAULT_CODE;
      att_code  <= DEFAULT_CODE;
      timer     <= '0;
      err       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (code_wr) code_q <= code_in;
          if (press_bad) begin
            err   <= 1'b1;
            state <= CHECK;
          end else if (press_valid) begin
            att_code  <= code_q;
            err       <= (digit != code_q[0]);
            entry_cnt <= 3'd1;
            timer     <= TIMEOUT_LOAD;
            state     <= (CODE_LEN == 1) ? CHECK : ENTRY;
          end
        end

        ENTRY: begin
          if (press_bad) begin
            err   <= 1'b1;
            state <= CHECK;
          end else if (press_valid) begin
            err       <= err | (digit != att_code[entry_cnt]);
            entry_cnt <= entry_cnt + 3'd1;
            timer     <= TIMEOUT_LOAD;
            if (entry_cnt == LAST_IDX) state <= CHECK;
          end else if (timer == '0) begin
            entry_cnt <= 3'd0;
            err       <= 1'b0;
            state     <= IDLE;
          end else begin
            timer <= timer - 1'b1;
          end
        end

        CHECK: begin
          entry_cnt <= 3'd0;
          err       <= 1'b0;
          if (!err) begin
            fail_cnt <= 2'd0;
            timer    <= UNLOCK_LOAD;
            state    <= OPEN;
          end else if ((fail_cnt + 2'd1) == FAIL_LIMIT) begin
            fail_cnt <= fail_cnt + 2'd1;
            lockout  <= 1'b1;
            timer    <= LOCKOUT_LOAD;
            state    <= LOCKOUT;
          end else begin
            fail_cnt <= fail_cnt + 2'd1;
            state    <= IDLE;
          end
        end

        OPEN: begin
          if (timer == '0) begin
            unlock <= 1'b0;
            state  <= IDLE;
          end else begin
            unlock <= 1'b1;
            timer  <= timer - 1'b1;
          end
        end

        LOCKOUT: begin
          if (timer == '0) begin
            lockout  <= 1'b0;
            fail_cnt <= 2'd0;
            state    <= IDLE;
          end else begin
            timer <= timer - 1'b1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
